// File: rtl/multiplier_arbiter.sv
// multiplier_arbiter: round-robin sharing of one combinational N x N unsigned
// array multiplier between R requesters, with a registered, ID-tagged response.
//
// Optional feature macro: MULTIPLIER_ARBITER_STATS_EN
//   defined   -> txn_count counts response handshakes, saturating at 16'hFFFF
//   undefined -> txn_count is tied to 0
//
// Ports:
//   clk, rst              clock (rising edge), async active-high reset
//   req_valid[R]          per-requester request valid
//   req_ready[R]          one-hot grant, combinational, only in IDLE
//   req_a, req_b[R*N]     operands, requester i on bits [i*N +: N]
//   rsp_valid, rsp_ready  response handshake
//   rsp_id                requester that owns rsp_p
//   rsp_p[2N]             exact unsigned product
//   txn_count[16]         completed-transaction counter

// Combinational array multiplier: sum of AND-gated, shifted partial-product rows.
module arraymultiplier #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic [2*N-1:0] p
);
  localparam int unsigned PW = 2 * N;

  always_comb begin
    p = '0;
    for (int unsigned i = 0; i < N; i++) begin
      p = p + (PW'(a & {N{b[i]}}) << i);
    end
  end
endmodule

module multiplier_arbiter #(
  parameter int unsigned N   = 4,
  parameter int unsigned R   = 4,
  parameter int unsigned LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [R-1:0]         req_valid,
  output logic [R-1:0]         req_ready,
  input  logic [R*N-1:0]       req_a,
  input  logic [R*N-1:0]       req_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [$clog2(R)-1:0] rsp_id,
  output logic [2*N-1:0]       rsp_p,
  output logic [15:0]          txn_count
);
  localparam int unsigned IW = $clog2(R);
  localparam int unsigned PW = 2 * N;
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] id_q;
  logic [N-1:0]  op_a, op_b;
  logic [CW-1:0] lat_cnt;
  logic [PW-1:0] mult_p;

  logic          grant_vld;
  logic [IW-1:0] grant_id;
  logic [IW-1:0] cand;
  logic          accept;
  logic          finish;
  logic          rsp_fire;

  arraymultiplier #(.N(N)) u_mult (
    .a(op_a),
    .b(op_b),
    .p(mult_p)
  );

  // Round-robin search: first valid requester at or after rr_ptr, with wrap.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    cand      = '0;
    for (int unsigned k = 0; k < R; k++) begin
      cand = IW'((32'(rr_ptr) + k) % R);
      if (!grant_vld && req_valid[cand]) begin
        grant_vld = 1'b1;
        grant_id  = cand;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state, grant and datapath strobes.
  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    accept    = 1'b0;
    finish    = 1'b0;
    rsp_fire  = 1'b0;
    case (state_q)
      IDLE: begin
        // Grant is masked while reset is asserted so no requester sees ready.
        if (grant_vld && !rst) begin
          req_ready[grant_id] = 1'b1;
          accept              = 1'b1;
          state_d             = EXEC;
        end
      end
      EXEC: begin
        if (lat_cnt == '0) begin
          finish  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (rsp_ready) begin
          rsp_fire = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand capture, settle counter, pointer advance and response register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr    <= '0;
      id_q      <= '0;
      op_a      <= '0;
      op_b      <= '0;
      lat_cnt   <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_p     <= '0;
    end else begin
      if (accept) begin
        op_a    <= req_a[32'(grant_id)*N +: N];
        op_b    <= req_b[32'(grant_id)*N +: N];
        id_q    <= grant_id;
        rr_ptr  <= (grant_id == IW'(R - 1)) ? '0 : grant_id + IW'(1);
        lat_cnt <= CW'(LAT - 1);
      end
      if (state_q == EXEC && lat_cnt != '0) begin
        lat_cnt <= lat_cnt - CW'(1);
      end
      if (finish) begin
        rsp_valid <= 1'b1;
        rsp_id    <= id_q;
        rsp_p     <= mult_p;
      end
      if (rsp_fire) begin
        rsp_valid <= 1'b0;
      end
    end
  end

`ifdef MULTIPLIER_ARBITER_STATS_EN
  // Saturating count of response handshakes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                   txn_count <= '0;
    else if (rsp_fire && txn_count != 16'hFFFF) txn_count <= txn_count + 16'd1;
  end
`else
  assign txn_count = '0;
`endif

endmodule

// File: tb/tb_multiplier_arbiter.sv
// Scoreboard bench for multiplier_arbiter: a LAT=1 instance carries the
// handshake, round-robin, backpressure and arithmetic vectors; a LAT=3
// instance covers settle latency, transaction counting and mid-operation reset.
module tb_multiplier_arbiter;
  localparam int unsigned N  = 4;
  localparam int unsigned R  = 4;
  localparam int unsigned IW = 2;
  localparam int unsigned PW = 8;

  typedef struct packed {
    logic [IW-1:0] id;
    logic [PW-1:0] p;
  } exp_t;

  logic          clk;
  logic          rst, rst3;
  logic [R-1:0]  req_valid, req_ready, req3_valid, req3_ready;
  logic [R*N-1:0] req_a, req_b, req3_a, req3_b;
  logic          rsp_valid, rsp_ready, rsp3_valid, rsp3_ready;
  logic [IW-1:0] rsp_id, rsp3_id;
  logic [PW-1:0] rsp_p, rsp3_p;
  logic [15:0]   txn_count, txn3_count;

  exp_t exp_q[$];
  exp_t e;
  int   errors   = 0;
  int   checks   = 0;
  int   n_exp    = 0;
  int   last_cyc = 0;
  logic [R-1:0] g;
  logic [R-1:0] exp_g[5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [N-1:0] ta[3] = '{4'd7, 4'd15, 4'd2};
  logic [N-1:0] tb[3] = '{4'd9, 4'd15, 4'd13};
  logic [PW-1:0] tp[3] = '{8'd63, 8'd225, 8'd26};
  int   exp_txn;

  multiplier_arbiter #(.N(N), .R(R), .LAT(1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_p(rsp_p), .txn_count(txn_count)
  );

  multiplier_arbiter #(.N(N), .R(R), .LAT(3)) dut3 (
    .clk(clk), .rst(rst3),
    .req_valid(req3_valid), .req_ready(req3_ready),
    .req_a(req3_a), .req_b(req3_b),
    .rsp_valid(rsp3_valid), .rsp_ready(rsp3_ready),
    .rsp_id(rsp3_id), .rsp_p(rsp3_p), .txn_count(txn3_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at t=%0t", name, act, want, $time);
    end
  endtask

  task automatic set_req(input int i, input logic [N-1:0] a, input logic [N-1:0] b);
    req_a[i*N +: N] = a;
    req_b[i*N +: N] = b;
    req_valid[i]    = 1'b1;
  endtask

  task automatic push(input logic [IW-1:0] id, input logic [PW-1:0] p);
    exp_t t;
    t.id = id;
    t.p  = p;
    exp_q.push_back(t);
    n_exp++;
  endtask

  // Wait (bounded) for any grant on the LAT=1 instance; sampled on negedge.
  task automatic wait_grant(output logic [R-1:0] gr);
    gr = '0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (|req_ready) begin
        gr       = req_ready;
        last_cyc = c + 1;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL grant_timeout: got no req_ready, want a grant at t=%0t", $time);
  endtask

  task automatic take(input logic [R-1:0] gr, input bit drop);
    @(posedge clk);
    #1;
    if (drop) req_valid = req_valid & ~gr;
  endtask

  task automatic drain();
    for (int c = 0; c < 60 && exp_q.size() != 0; c++) @(posedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d responses outstanding, want 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: every response handshake pops and compares one expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rsp_unexpected: got id=%0d p=%0d, want no response", rsp_id, rsp_p);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_id", 32'(rsp_id), 32'(e.id));
          chk("rsp_p", 32'(rsp_p), 32'(e.p));
        end
      end
    end
  end

  initial begin
    rst = 1'b1;  rst3 = 1'b1;
    req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    req3_valid = '0; req3_a = '0; req3_b = '0; rsp3_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_rsp_p", 32'(rsp_p), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_txn_count", 32'(txn_count), 32'd0);
    rst = 1'b0;

    // Test 1: single request from requester 1, 3*5
    rsp_ready = 1'b1;
    set_req(1, 4'd3, 4'd5);
    push(2'd1, 8'd15);
    wait_grant(g);
    chk("t1_grant", 32'(g), 32'b0010);
    take(g, 1'b1);
    chk("t1_exec_valid", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    chk("t1_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("t1_rsp_p", 32'(rsp_p), 32'd15);
    chk("t1_rsp_id", 32'(rsp_id), 32'd1);
    @(posedge clk); #1;
    chk("t1_rsp_drop", 32'(rsp_valid), 32'd0);
    drain();

    // Test 2: all four requesting from reset
    rst = 1'b1;
    for (int i = 0; i < 4; i++) set_req(i, 4'(i + 1), 4'd2);
    @(negedge clk);
    chk("rst_ready_gated", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    n_exp = 0;
    push(2'd0, 8'd2); push(2'd1, 8'd4); push(2'd2, 8'd6); push(2'd3, 8'd8); push(2'd0, 8'd2);
    for (int k = 0; k < 5; k++) begin
      wait_grant(g);
      chk("t2_grant", 32'(g), 32'(exp_g[k]));
      if (k > 0) chk("t2_spacing", 32'(last_cyc), 32'd3);
      take(g, 1'b0);
      if (k == 4) req_valid = '0;
    end
    drain();

    // Test 3: round-robin after a grant to 2
    set_req(2, 4'd2, 4'd7);
    push(2'd2, 8'd14);
    wait_grant(g);
    chk("t3_grant2", 32'(g), 32'b0100);
    take(g, 1'b1);
    set_req(3, 4'd5, 4'd3);
    set_req(0, 4'd6, 4'd6);
    push(2'd3, 8'd15);
    push(2'd0, 8'd36);
    wait_grant(g);
    chk("t3_grant3", 32'(g), 32'b1000);
    take(g, 1'b1);
    wait_grant(g);
    chk("t3_grant0", 32'(g), 32'b0001);
    take(g, 1'b1);
    drain();

    // Test 4: backpressure in DONE with another requester waiting
    rsp_ready = 1'b0;
    set_req(1, 4'd9, 4'd11);
    push(2'd1, 8'd99);
    wait_grant(g);
    chk("t4_grant1", 32'(g), 32'b0010);
    take(g, 1'b1);
    set_req(2, 4'd4, 4'd4);
    push(2'd2, 8'd16);
    @(posedge clk); #1;
    for (int c = 0; c < 5; c++) begin
      chk("t4_hold_valid", 32'(rsp_valid), 32'd1);
      chk("t4_hold_p", 32'(rsp_p), 32'd99);
      chk("t4_hold_id", 32'(rsp_id), 32'd1);
      chk("t4_hold_ready", 32'(req_ready), 32'd0);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    wait_grant(g);
    chk("t4_grant2", 32'(g), 32'b0100);
    take(g, 1'b1);
    drain();

    // Test 5: every operand pair through requester 0
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        req_valid = '0;
        set_req(0, 4'(a), 4'(b));
        push(2'd0, (a == 15 && b == 15) ? 8'd225 : 8'(a * b));
        wait_grant(g);
        take(g, 1'b1);
      end
    end
    drain();

`ifdef MULTIPLIER_ARBITER_STATS_EN
    exp_txn = n_exp;
`else
    exp_txn = 0;
`endif
    chk("txn_count", 32'(txn_count), 32'(exp_txn));

    // Test 6: LAT=3 instance, three transactions then reset mid-EXEC
    rst3 = 1'b0;
    rsp3_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      req3_valid = '0;
      req3_a[j*N +: N] = ta[j];
      req3_b[j*N +: N] = tb[j];
      req3_valid[j] = 1'b1;
      @(negedge clk);
      chk("t6_grant", 32'(req3_ready), 32'(4'(1 << j)));
      @(posedge clk); #1;
      req3_valid = '0;
      for (int c = 0; c < 3; c++) begin
        chk("t6_settle_valid", 32'(rsp3_valid), 32'd0);
        @(posedge clk); #1;
      end
      chk("t6_rsp_valid", 32'(rsp3_valid), 32'd1);
      chk("t6_rsp_p", 32'(rsp3_p), 32'(tp[j]));
      chk("t6_rsp_id", 32'(rsp3_id), 32'(j));
      @(posedge clk); #1;
      chk("t6_rsp_drop", 32'(rsp3_valid), 32'd0);
    end
`ifdef MULTIPLIER_ARBITER_STATS_EN
    exp_txn = 3;
`else
    exp_txn = 0;
`endif
    chk("t6_txn_count", 32'(txn3_count), 32'(exp_txn));

    req3_a[3*N +: N] = 4'd5;
    req3_b[3*N +: N] = 4'd5;
    req3_valid[3] = 1'b1;
    @(negedge clk);
    chk("t6_grant3", 32'(req3_ready), 32'b1000);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst3 = 1'b1;
    #1;
    chk("t6_rst_valid", 32'(rsp3_valid), 32'd0);
    chk("t6_rst_id", 32'(rsp3_id), 32'd0);
    chk("t6_rst_p", 32'(rsp3_p), 32'd0);
    chk("t6_rst_ready", 32'(req3_ready), 32'd0);
    chk("t6_rst_txn", 32'(txn3_count), 32'd0);
    req3_valid = '0;
    repeat (2) @(posedge clk);
    #1;
    rst3 = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      chk("t6_no_pulse", 32'(rsp3_valid), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/multiplier_arbiter.md
Name: multiplier_arbiter

Overview:
Shares one combinational arraymultiplier #(N) instance, instantiated inside this block, between R requesters.
- Arbitration is round-robin.
- Each requester uses a valid/ready handshake on its request channel.
- Results return on a single registered response channel tagged with the requester ID.
- The block sits between the multiplier datapath and client logic that needs occasional N x N unsigned products.

Parameters:
N, 4, operand width in bits; product width is 2N.
R, 4, number of requesters, 2..8.
LAT, 1, settle cycles allowed for the combinational multiplier after operands are registered, 1..15.

Ports:
clk  in  1  single clock, rising edge.
rst  in  1  asynchronous reset, active-high.
req_valid  in  R  request valid, bit i belongs to requester i.
req_ready  out  R  request accepted; at most one bit high.
req_a  in  R*N  operand a; requester i drives bits [i*N +: N].
req_b  in  R*N  operand b; same packing as req_a.
rsp_valid  out  1  response valid.
rsp_ready  in  1  response consumer ready.
rsp_id  out  clog2(R)  index of the requester that owns rsp_p.
rsp_p  out  2N  product a*b, unsigned, exact.
txn_count  out  16  completed-transaction counter (see Optional Feature).

Behaviour:
- Reset (async assert; release synchronous to clk):
  - state=IDLE, rr_ptr=0.
  - rsp_valid=0, rsp_id=0, rsp_p=0, req_ready=0.
  - Internal operand registers op_a=0, op_b=0, lat counter=0, txn_count=0.
- Reset mid-transaction: the in-flight operation is discarded and no response is issued. Requesters must re-present after reset.
- FSM states:
  - IDLE:
    - Grant goes to the first requester with req_valid high, searching from rr_ptr upward with wrap (rr_ptr, rr_ptr+1, ... R-1, 0, ...).
    - req_ready[winner] is high combinationally; all other req_ready bits are 0.
    - No requests: stay in IDLE with req_ready=0.
    - On the clk edge where req_valid[w] & req_ready[w]:
      - op_a, op_b latch requester w's operands; id_q=w.
      - rr_ptr = (w+1) mod R.
      - lat counter = LAT-1; go to EXEC.
  - EXEC:
    - req_ready=0.
    - The multiplier inputs are op_a and op_b (registered, stable).
    - When the lat counter reaches 0: rsp_p=mult_p, rsp_id=id_q, rsp_valid=1, go to DONE. Otherwise decrement the counter.
  - DONE:
    - req_ready=0; rsp_valid stays 1 and rsp_p/rsp_id stay stable until rsp_ready is high.
    - On rsp_valid & rsp_ready: rsp_valid=0, go to IDLE. A new grant is possible on the following cycle; there is no IDLE bypass.
- Latency: request accepted at edge t gives rsp_valid=1 from edge t+LAT onward. Minimum spacing between acceptances is LAT+2 cycles when rsp_ready is tied high.
- rsp_ready is ignored outside DONE.
- Requester fairness:
  - A requester holding req_valid high is granted within R transactions.
  - req_valid may drop without a grant; nothing is latched for that requester.
- Arithmetic: full-width unsigned product. 0*x=0. (2^N-1)^2 = 2^(2N) - 2^(N+1) + 1, which fits in 2N bits with no overflow.
- rr_ptr wraps from R-1 to 0.

Optional Feature:
MULTIPLIER_ARBITER_STATS_EN
- Defined: txn_count increments on every rsp_valid & rsp_ready handshake. It saturates at 16'hFFFF. It resets to 0 on rst.
- Undefined: txn_count is constant 0 and no counter logic is synthesised. The port list is identical in both cases.

Test Plan:
1. Single request: reset, then req_valid[1]=1, a=3, b=5, rsp_ready=1, LAT=1. Required: accepted at edge t; rsp_valid=1 at edge t+1 with rsp_p=15, rsp_id=1; rsp_valid=0 one cycle later.
2. All-request contention: req_valid=4'b1111 held from reset; requester i uses a=i+1, b=2. Required: responses in rsp_id order 0,1,2,3,0 with products 2,4,6,8,2.
3. Round-robin pointer: after a grant to requester 2, assert req_valid=4'b1001. Required: next grant goes to 3, then 0.
4. Backpressure: hold rsp_ready=0 for 5 cycles while in DONE. Required: rsp_p, rsp_id, rsp_valid stable; req_ready=0 throughout; exactly one response when rsp_ready rises.
5. Exhaustive arithmetic with N=4 via requester 0: all 256 (a,b) pairs. Required: rsp_p==a*b for every pair, including 15*15=225.
6. Mid-operation reset: assert rst in EXEC with LAT=3. Required: all outputs return to reset values immediately, no rsp_valid pulse, and txn_count=0 when MULTIPLIER_ARBITER_STATS_EN is defined. A separate run with the macro defined and 3 completed transactions requires txn_count=3.
